router_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router input path. It sits directly upstream of `router_reg_new` and drives its capture strobes from `packet_valid_i`, the stored data size and FIFO back-pressure. It also drives `full_state`, so the register block holds data while the FIFO is full. It judges each packet complete or dropped from the register block's CRC and source-check results.

---
 rtl/router_fsm_pkg.sv | 23 ++
 rtl/router_stall_timer.sv | 28 ++
 rtl/router_fsm.sv | 91 +++++++++
 tb/tb_router_fsm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_fsm_pkg.sv
// router_fsm_pkg: state encodings, default watchdog limit and the size-field convention for the router input path
package router_fsm_pkg;

    localparam int TIMEOUT_DEF = 30;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEST      = 4'd1,
        S_HEADER    = 4'd2,
        S_SIZE      = 4'd3,
        S_DATA      = 4'd4,
        S_FULL_WAIT = 4'd5,
        S_CRC       = 4'd6,
        S_CHECK     = 4'd7,
        S_DROP      = 4'd8
    } state_t;

    // Index of the last data byte; a size field of 0 means 8 bytes, which wraps to index 7.
    function automatic logic [2:0] last_idx(input logic [2:0] dsize);
        return dsize - 3'd1;
    endfunction

endpackage

// File: rtl/router_stall_timer.sv
// router_stall_timer: clearable saturating idle-cycle counter with a terminal-count flag
module router_stall_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk1,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // Fires on the idle cycle that brings the count up to TIMEOUT.
    assign o_tc = i_inc && (r_cnt >= W'(TIMEOUT - 1));

    // Count consecutive idle cycles, saturating so a long stall cannot wrap.
    always_ff @(posedge clk1 or posedge reset)
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != W'(TIMEOUT))
            r_cnt <= r_cnt + 1'b1;

endmodule

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller driving the router register block's capture strobes
module router_fsm
    import router_fsm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       packet_valid_i,
    input  logic       fifo_full,
    input  logic [2:0] dsize,
    input  logic       crc_checked,
    input  logic       trusted_source,
    input  logic       err,
    output logic       get_source,
    output logic       get_dest,
    output logic       store_header,
    output logic       get_size,
    output logic       load_data,
    output logic       get_crc,
    output logic       full_state,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_drop
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic       w_beat;
    logic       w_stall;
    logic       w_timeout;
    logic       w_on;
    logic       w_good;

    // A byte in DATA only counts when the FIFO can take it.
    assign w_beat  = packet_valid_i && !(r_state == S_DATA && fifo_full);
    assign w_stall = !packet_valid_i && (r_state inside {S_DEST, S_SIZE, S_DATA, S_CRC});
    assign w_on    = !reset;
    assign w_good  = crc_checked && trusted_source && !err;

    router_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall (
        .clk1  (clk1),
        .reset (reset),
        .i_clr (!w_stall),
        .i_inc (w_stall),
        .o_tc  (w_timeout)
    );

    // State register and data-beat counter; the counter is zeroed while in SIZE so it starts at 0 in DATA.
    always_ff @(posedge clk1 or posedge reset)
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_SIZE)
                r_cnt <= '0;
            else if (r_state == S_DATA && w_beat)
                r_cnt <= r_cnt + 3'd1;
        end

    // Next-state decode with watchdog override, plus strobes gated off while reset is held.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_beat) w_next = S_DEST;
            S_DEST:      if (w_beat) w_next = S_HEADER;
            S_HEADER:    w_next = S_SIZE;
            S_SIZE:      if (w_beat) w_next = S_DATA;
            S_DATA:      if (packet_valid_i && fifo_full) w_next = S_FULL_WAIT;
                         else if (w_beat && r_cnt == last_idx(dsize)) w_next = S_CRC;
            S_FULL_WAIT: if (!fifo_full) w_next = S_DATA;
            S_CRC:       if (w_beat) w_next = S_CHECK;
            default:     w_next = S_IDLE;
        endcase
        if (w_timeout)
            w_next = S_DROP;
        get_source   = w_on && r_state == S_IDLE && w_beat;
        get_dest     = w_on && r_state == S_DEST && w_beat;
        store_header = w_on && r_state == S_HEADER;
        get_size     = w_on && r_state == S_SIZE && w_beat;
        load_data    = w_on && r_state == S_DATA && w_beat;
        get_crc      = w_on && r_state == S_CRC && w_beat;
        full_state   = w_on && r_state == S_FULL_WAIT;
        busy         = w_on && (r_state inside {S_HEADER, S_FULL_WAIT, S_CHECK, S_DROP});
        pkt_done     = w_on && r_state == S_CHECK && w_good;
        pkt_drop     = w_on && (r_state == S_DROP || (r_state == S_CHECK && !w_good));
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed and randomized checks of router_fsm against a packet-level reference model
module tb_router_fsm;

    localparam int TO = 30;
    localparam int B_SRC = 9, B_DST = 8, B_HDR = 7, B_SIZE = 6, B_LD = 5;
    localparam int B_CRC = 4, B_FS = 3, B_BUSY = 2, B_DONE = 1, B_DROP = 0;

    logic       clk1 = 1'b0;
    logic       reset = 1'b1;
    logic       packet_valid_i = 1'b0;
    logic       fifo_full = 1'b0;
    logic [2:0] dsize = 3'd0;
    logic       crc_checked = 1'b0;
    logic       trusted_source = 1'b0;
    logic       err = 1'b0;
    logic       get_source, get_dest, store_header, get_size, load_data, get_crc;
    logic       full_state, busy, pkt_done, pkt_drop;
    logic [9:0] w_out;
    logic [9:0] smp;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes accepted so far in the packet plus one-cycle phase flags.
    int m_idx = 0;
    int m_stall = 0;
    bit m_hdr = 0, m_fw = 0, m_chk = 0, m_drp = 0;

    int n[10];
    int t[10];

    router_fsm #(.TIMEOUT(TO)) dut (
        .clk1           (clk1),
        .reset          (reset),
        .packet_valid_i (packet_valid_i),
        .fifo_full      (fifo_full),
        .dsize          (dsize),
        .crc_checked    (crc_checked),
        .trusted_source (trusted_source),
        .err            (err),
        .get_source     (get_source),
        .get_dest       (get_dest),
        .store_header   (store_header),
        .get_size       (get_size),
        .load_data      (load_data),
        .get_crc        (get_crc),
        .full_state     (full_state),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .pkt_drop       (pkt_drop)
    );

    assign w_out = {get_source, get_dest, store_header, get_size, load_data,
                    get_crc, full_state, busy, pkt_done, pkt_drop};

    always #5 clk1 = ~clk1;

    function automatic int size_n();
        return (dsize == 3'd0) ? 8 : int'(dsize);
    endfunction

    function automatic logic [9:0] model_out();
        logic [9:0] e;
        e = '0;
        if (reset) return e;
        if (m_drp) begin
            e[B_DROP] = 1'b1; e[B_BUSY] = 1'b1;
        end else if (m_chk) begin
            e[B_DONE] = crc_checked && trusted_source && !err;
            e[B_DROP] = !e[B_DONE];
            e[B_BUSY] = 1'b1;
        end else if (m_hdr) begin
            e[B_HDR] = 1'b1; e[B_BUSY] = 1'b1;
        end else if (m_fw) begin
            e[B_FS] = 1'b1; e[B_BUSY] = 1'b1;
        end else if (m_idx == 0) e[B_SRC] = packet_valid_i;
        else if (m_idx == 1) e[B_DST] = packet_valid_i;
        else if (m_idx == 2) e[B_SIZE] = packet_valid_i;
        else if (m_idx < 3 + size_n()) e[B_LD] = packet_valid_i && !fifo_full;
        else e[B_CRC] = packet_valid_i;
        return e;
    endfunction

    task automatic model_step();
        int nn;
        nn = size_n();
        if (reset) begin
            m_idx = 0; m_stall = 0; m_hdr = 0; m_fw = 0; m_chk = 0; m_drp = 0;
        end else if (m_drp || m_chk) begin
            m_idx = 0; m_stall = 0; m_drp = 0; m_chk = 0;
        end else if (m_hdr) begin
            m_hdr = 0; m_stall = 0;
        end else if (m_fw) begin
            m_stall = 0;
            if (!fifo_full) m_fw = 0;
        end else if (!packet_valid_i) begin
            if (m_idx > 0) begin
                m_stall++;
                if (m_stall == TO) begin
                    m_drp = 1; m_stall = 0; m_idx = 0;
                end
            end
        end else begin
            m_stall = 0;
            if (m_idx >= 3 && m_idx < 3 + nn && fifo_full) m_fw = 1;
            else begin
                if (m_idx == 1) m_hdr = 1;
                if (m_idx == 3 + nn) m_chk = 1;
                m_idx++;
            end
        end
    endtask

    // One clock: drive just after the edge, compare mid-cycle, advance the model at the next edge.
    task automatic tick(input logic v, ff, rs, input logic [2:0] ds, input logic cc, ts, er);
        logic [9:0] e;
        #1;
        packet_valid_i = v; fifo_full = ff; reset = rs; dsize = ds;
        crc_checked = cc; trusted_source = ts; err = er;
        @(negedge clk1);
        e = model_out();
        smp = w_out;
        checks++;
        if (smp !== e) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got=%b want=%b", $time, smp, e);
        end
        @(posedge clk1);
        model_step();
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Drive one packet-shaped valid window with optional FIFO-full and idle gaps, tallying each output.
    task automatic run(input logic [2:0] ds, input int total, fs, fl, gs, gl, post,
                       input logic cc, ts, er);
        for (int b = 0; b < 10; b++) begin n[b] = 0; t[b] = -1; end
        for (int i = 0; i < total + post; i++) begin
            tick(i < total && !(i >= gs && i < gs + gl), i >= fs && i < fs + fl, 1'b0, ds, cc, ts, er);
            for (int b = 0; b < 10; b++)
                if (smp[b]) begin
                    n[b]++;
                    if (t[b] < 0) t[b] = i;
                end
        end
    endtask

    initial begin
        int gap;
        logic v, ff, rs;
        logic [2:0] ds;
        tick(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        chk("reset_outs", int'(smp), 0);
        tick(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        chk("post_reset_outs", int'(smp), 0);

        run(3'd2, 7, 99, 0, 99, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("good2_src_cyc", t[B_SRC], 0);
        chk("good2_dst_cyc", t[B_DST], 1);
        chk("good2_hdr_cyc", t[B_HDR], 2);
        chk("good2_size_cyc", t[B_SIZE], 3);
        chk("good2_ld_cyc", t[B_LD], 4);
        chk("good2_ld_cnt", n[B_LD], 2);
        chk("good2_crc_cyc", t[B_CRC], 6);
        chk("good2_done_cyc", t[B_DONE], 7);
        chk("good2_done_cnt", n[B_DONE], 1);
        chk("good2_drop_cnt", n[B_DROP], 0);
        chk("good2_src_cnt", n[B_SRC], 1);
        chk("good2_busy_cnt", n[B_BUSY], 2);

        run(3'd3, 8, 99, 0, 99, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("size3_ld_cnt", n[B_LD], 3);
        chk("size3_crc_cyc", t[B_CRC], 7);
        chk("size3_done_cyc", t[B_DONE], 8);

        run(3'd0, 13, 99, 0, 99, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("size8_ld_cnt", n[B_LD], 8);
        chk("size8_crc_cyc", t[B_CRC], 12);
        chk("size8_done_cyc", t[B_DONE], 13);

        run(3'd2, 12, 5, 4, 99, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("full_fs_cnt", n[B_FS], 4);
        chk("full_fs_cyc", t[B_FS], 6);
        chk("full_ld_cnt", n[B_LD], 2);
        chk("full_busy_cnt", n[B_BUSY], 6);
        chk("full_done_cyc", t[B_DONE], 12);

        run(3'd2, 7, 99, 0, 99, 0, 3, 1'b1, 1'b1, 1'b1);
        chk("crcerr_drop_cyc", t[B_DROP], 7);
        chk("crcerr_drop_cnt", n[B_DROP], 1);
        chk("crcerr_done_cnt", n[B_DONE], 0);

        run(3'd2, 7, 99, 0, 99, 0, 3, 1'b1, 1'b0, 1'b0);
        chk("untrusted_drop_cnt", n[B_DROP], 1);
        chk("untrusted_done_cnt", n[B_DONE], 0);

        run(3'd2, 5, 99, 0, 99, 0, 32, 1'b1, 1'b1, 1'b0);
        chk("timeout_drop_cyc", t[B_DROP], 35);
        chk("timeout_drop_cnt", n[B_DROP], 1);
        chk("timeout_done_cnt", n[B_DONE], 0);

        run(3'd2, 36, 99, 0, 5, 29, 3, 1'b1, 1'b1, 1'b0);
        chk("gap29_done_cyc", t[B_DONE], 36);
        chk("gap29_drop_cnt", n[B_DROP], 0);
        chk("gap29_ld_cnt", n[B_LD], 2);

        run(3'd2, 5, 99, 0, 99, 0, 0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        chk("midreset_outs", int'(smp), 0);
        tick(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        chk("midreset_release_outs", int'(smp), 0);
        run(3'd2, 7, 99, 0, 99, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("after_reset_src_cyc", t[B_SRC], 0);
        chk("after_reset_done_cyc", t[B_DONE], 7);
        chk("after_reset_drop_cnt", n[B_DROP], 0);

        gap = 0;
        ds = 3'd2;
        for (int i = 0; i < 5000; i++) begin
            if (gap > 0) begin
                v = 1'b0; gap--;
            end else if ($urandom_range(0, 79) == 0) begin
                v = 1'b0; gap = int'($urandom_range(26, 34));
            end else v = ($urandom_range(0, 3) != 0);
            ff = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 599) == 0);
            if (m_idx == 0 && !m_hdr && !m_fw && !m_chk && !m_drp) ds = 3'($urandom_range(0, 7));
            tick(v, ff, rs, ds, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
